// File: rtl/aes_dec_pkg.sv
// Shared constants and types for the AES decrypt block fetcher.
// Word and block widths, plus the fetch FSM state encoding.
package aes_dec_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int MEM_WORD_W    = 32;
  localparam int MEM_AW        = 13;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD,
    FINISH
  } fetch_state_t;

endpackage

// File: rtl/aes_dec_blk_fetch.sv
// Avalon-MM read master: fetches 128-bit ciphertext blocks from
// on-chip memory and streams them out over valid/ready.
module aes_dec_blk_fetch
  import aes_dec_pkg::*;
#(
  parameter int MEM_AW = 13,
  parameter int CNT_W  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_AW-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_blocks,
  output logic                  busy,
  output logic                  done,
  output logic [MEM_AW-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [3:0]            avm_byteenable,
  input  logic [MEM_WORD_W-1:0] avm_readdata,
  output logic [AES_BLK_W-1:0]  blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready
);

  fetch_state_t state, state_n;

  logic [1:0]           off;
  logic [MEM_AW-1:0]    addr;
  logic [CNT_W-1:0]     remaining;
  logic                 busy_q;
  logic [AES_BLK_W-1:0] blk_asm;
  logic                 hs;
  logic                 out_free;
  logic                 move;

  assign hs       = blk_valid & blk_ready;
  assign out_free = ~blk_valid | hs;

  assign busy           = busy_q;
  assign done           = (state == FINISH);
  assign avm_chipselect = (state == ISSUE);
  assign avm_address    = (state == ISSUE) ? addr + MEM_AW'(off) : '0;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;

  always_comb begin
    state_n = state;
    move    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (num_blocks == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (off == 2'd3)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (out_free) begin
          move    = 1'b1;
          state_n = (remaining == CNT_W'(1)) ? HOLD : ISSUE;
        end else begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        // remaining == 0 here means the last block is already staged
        if (remaining == '0) begin
          if (hs)
            state_n = FINISH;
        end else if (out_free) begin
          move    = 1'b1;
          state_n = (remaining == CNT_W'(1)) ? HOLD : ISSUE;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      off       <= '0;
      addr      <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      blk_asm   <= '0;
      blk_data  <= '0;
      blk_valid <= 1'b0;
    end else begin
      state <= state_n;

      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= num_blocks;
        busy_q    <= (num_blocks != '0);
      end
      if (state == FINISH)
        busy_q <= 1'b0;

      // Read data lags the strobe by one cycle, so word off-1 lands now
      if (state == ISSUE) begin
        off <= off + 2'd1;
        case (off)
          2'd1:    blk_asm[127:96] <= avm_readdata;
          2'd2:    blk_asm[95:64]  <= avm_readdata;
          2'd3:    blk_asm[63:32]  <= avm_readdata;
          default: ;
        endcase
        if (off == 2'd3)
          addr <= addr + MEM_AW'(WORDS_PER_BLK);
      end
      if (state == DRAIN)
        blk_asm[31:0] <= avm_readdata;

      if (move) begin
        remaining <= remaining - CNT_W'(1);
        blk_valid <= 1'b1;
        blk_data  <= (state == DRAIN) ?
                     {blk_asm[127:32], avm_readdata} : blk_asm;
      end else if (hs) begin
        blk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_blk_fetch.sv
// Directed bench for aes_dec_blk_fetch with a latency-1 memory model.
// Logs bus activity at negedge and checks against hand-derived cycles.
module tb_aes_dec_blk_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [12:0]  base_addr;
  logic [11:0]  num_blocks;
  logic         busy;
  logic         done;
  logic [12:0]  avm_address;
  logic         avm_chipselect;
  logic         avm_write;
  logic [3:0]   avm_byteenable;
  logic [31:0]  avm_readdata;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;

  aes_dec_blk_fetch #(.MEM_AW(13), .CNT_W(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_blocks     (num_blocks),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .blk_data       (blk_data),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (avm_chipselect) avm_readdata <= mem[avm_address];

  int           n_chk = 0;
  int           n_pass = 0;
  int           cs_addr[$];
  int           cs_cyc[$];
  logic [127:0] hs_data[$];
  int           hs_cyc[$];
  int           rise_cyc[$];
  int           done_cyc[$];
  logic         busy_at_done[$];
  int           stall_viol = 0;
  logic         busy_seen = 1'b0;
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [127:0] pd = '0;

  always @(negedge clk) begin
    if (avm_chipselect) begin
      cs_addr.push_back(int'(avm_address));
      cs_cyc.push_back(cyc);
    end
    if (blk_valid && !pv) rise_cyc.push_back(cyc);
    if (blk_valid && blk_ready) begin
      hs_data.push_back(blk_data);
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      busy_at_done.push_back(busy);
    end
    if (busy) busy_seen = 1'b1;
    if (pv && !pr && blk_data != pd) stall_viol++;
    pv = blk_valid;
    pr = blk_ready;
    pd = blk_data;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] exp_blk(input int a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[127-32*k -: 32] = mem[(a + k) % 8192];
    return r;
  endfunction

  task automatic clear_logs();
    cs_addr.delete();
    cs_cyc.delete();
    hs_data.delete();
    hs_cyc.delete();
    rise_cyc.delete();
    done_cyc.delete();
    busy_at_done.delete();
    stall_viol = 0;
    busy_seen = 1'b0;
  endtask

  task automatic kick(input int b, input int n, output int t);
    @(posedge clk); #1;
    base_addr = 13'(b);
    num_blocks = 12'(n);
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim && done_cyc.size() == 0; i++)
      @(negedge clk);
    if (done_cyc.size() == 0) check({tag, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cs"}, avm_chipselect, 0);
    check({tag, "_addr"}, avm_address, 0);
    check({tag, "_valid"}, blk_valid, 0);
    check({tag, "_data"}, blk_data, 0);
  endtask

  int t;

  initial begin
    for (int i = 0; i < 8192; i++)
      mem[i] = 32'hA5000000 ^ (32'(i) * 32'h00010003);
    mem[16] = 32'h00112233;
    mem[17] = 32'h44556677;
    mem[18] = 32'h8899AABB;
    mem[19] = 32'hCCDDEEFF;

    reset = 1'b1; start = 1'b0; base_addr = '0;
    num_blocks = '0; blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_reset("por");
    check("por_we", avm_write, 0);
    check("por_be", avm_byteenable, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;

    // single block
    clear_logs();
    kick(16, 1, t);
    wait_done("single", 40);
    check("single_ncs", cs_addr.size(), 4);
    for (int k = 0; k < 4 && k < cs_addr.size(); k++) begin
      check($sformatf("single_addr%0d", k), cs_addr[k], 16 + k);
      check($sformatf("single_cscyc%0d", k), cs_cyc[k], t + 1 + k);
    end
    check("single_nhs", hs_data.size(), 1);
    if (hs_data.size() > 0) begin
      check("single_data", hs_data[0],
            128'h00112233_44556677_8899AABB_CCDDEEFF);
      check("single_vcyc", hs_cyc[0], t + 6);
    end
    check("single_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check("single_donecyc", done_cyc[0], t + 7);
      check("single_busy_done", busy_at_done[0], 1);
    end
    check("single_idle_busy", busy, 0);

    // streaming
    clear_logs();
    kick(100, 4, t);
    wait_done("stream", 80);
    check("stream_ncs", cs_addr.size(), 16);
    for (int k = 0; k < 16 && k < cs_addr.size(); k++)
      check($sformatf("stream_addr%0d", k), cs_addr[k], 100 + k);
    check("stream_nrise", rise_cyc.size(), 4);
    for (int b = 0; b < 4 && b < rise_cyc.size(); b++)
      check($sformatf("stream_rise%0d", b), rise_cyc[b], t + 6 + 5 * b);
    check("stream_nhs", hs_data.size(), 4);
    for (int b = 0; b < 4 && b < hs_data.size(); b++)
      check($sformatf("stream_data%0d", b), hs_data[b], exp_blk(100 + 4 * b));
    check("stream_ndone", done_cyc.size(), 1);

    // backpressure
    clear_logs();
    blk_ready = 1'b0;
    kick(200, 3, t);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("bp_stall_ncs", cs_addr.size(), 8);
    check("bp_stall_valid", blk_valid, 1);
    check("bp_stall_data", blk_data, exp_blk(200));
    @(posedge clk); #1;
    blk_ready = 1'b1;
    wait_done("bp", 80);
    check("bp_ncs", cs_addr.size(), 12);
    check("bp_nhs", hs_data.size(), 3);
    for (int b = 0; b < 3 && b < hs_data.size(); b++)
      check($sformatf("bp_data%0d", b), hs_data[b], exp_blk(200 + 4 * b));
    check("bp_stable", stall_viol, 0);
    check("bp_ndone", done_cyc.size(), 1);

    // address wrap
    clear_logs();
    kick(8190, 1, t);
    wait_done("wrap", 40);
    check("wrap_ncs", cs_addr.size(), 4);
    if (cs_addr.size() == 4) begin
      check("wrap_a0", cs_addr[0], 8190);
      check("wrap_a1", cs_addr[1], 8191);
      check("wrap_a2", cs_addr[2], 0);
      check("wrap_a3", cs_addr[3], 1);
    end
    check("wrap_nhs", hs_data.size(), 1);
    if (hs_data.size() > 0)
      check("wrap_data", hs_data[0],
            {mem[8190], mem[8191], mem[0], mem[1]});

    // zero blocks
    clear_logs();
    kick(50, 0, t);
    wait_done("zero", 20);
    check("zero_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("zero_donecyc", done_cyc[0], t + 1);
    check("zero_ncs", cs_addr.size(), 0);
    check("zero_busy", busy_seen, 0);

    // reset in the second issue cycle
    clear_logs();
    kick(300, 2, t);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cyc", cyc, t + 3);
    check_outputs_reset("rst");
    repeat (15) @(negedge clk);
    check("rst_ndone", done_cyc.size(), 0);
    check("rst_ncs", cs_addr.size(), 2);

    // start while busy is ignored
    clear_logs();
    kick(400, 2, t);
    @(posedge clk); #1;
    base_addr = 13'd900;
    num_blocks = 12'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", 60);
    check("ign_ncs", cs_addr.size(), 8);
    for (int k = 0; k < 8 && k < cs_addr.size(); k++)
      check($sformatf("ign_addr%0d", k), cs_addr[k], 400 + k);
    check("ign_nhs", hs_data.size(), 2);
    check("ign_ndone", done_cyc.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
